// File: rtl/cam_pkg.sv
// Shared constants, FSM state type and index helpers for the CAM dictionary encoder.
package cam_pkg;

  localparam int NB_MEM     = 16;
  localparam int SIZE_ADDR  = 4;
  localparam int CAM_IDX_W  = 5;
  localparam int CAM_DATA_W = 8;

  // Selects the live index bits of a CAM-width index; the pad bit is always 0.
  localparam logic [CAM_IDX_W-1:0] IDX_MASK = CAM_IDX_W'((1 << SIZE_ADDR) - 1);

  typedef enum logic [2:0] {
    IDLE,
    SEARCH,
    RESULT,
    WRITE,
    EMIT
  } state_t;

  function automatic logic [CAM_IDX_W-1:0] pad_idx(input logic [SIZE_ADDR-1:0] idx);
    return {{(CAM_IDX_W - SIZE_ADDR){1'b0}}, idx};
  endfunction

endpackage

// File: rtl/cam_encoder.sv
// Dictionary encoder: searches the 16-entry byte CAM for each input byte, emits the
// index on a hit, or inserts the byte at a round-robin slot and emits it as new.
module cam_encoder
  import cam_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CAM_DATA_W-1:0] in_byte,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_hit,
  output logic                  out_new,
  output logic [CAM_IDX_W-1:0]  out_idx,
  output logic [CAM_DATA_W-1:0] out_byte,
  output logic                  dict_full,
  output logic                  cam_enable,
  output logic                  cam_write,
  output logic [CAM_IDX_W-1:0]  cam_addr,
  output logic [CAM_DATA_W-1:0] cam_data,
  input  logic [CAM_IDX_W-1:0]  cam_out,
  input  logic                  cam_found
);

  state_t                  state, state_nx;
  logic [CAM_DATA_W-1:0]   cur_byte;
  logic [SIZE_ADDR-1:0]    alloc_ptr;
  logic                    accept;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == EMIT);
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, otherwise paths that
    // skip an assignment would infer a latch.
    state_nx   = state;
    cam_enable = 1'b0;
    cam_write  = 1'b0;
    cam_addr   = '0;
    cam_data   = '0;
    unique case (state)
      // Zero bytes bypass the CAM: its reset contents are all-zero and would falsely match.
      IDLE:    if (accept) state_nx = (in_byte == '0) ? EMIT : SEARCH;
      SEARCH: begin
        cam_enable = 1'b1;
        cam_data   = cur_byte;
        state_nx   = RESULT;
      end
      RESULT:  state_nx = cam_found ? EMIT : WRITE;
      WRITE: begin
        cam_write = 1'b1;
        cam_addr  = pad_idx(alloc_ptr);
        cam_data  = cur_byte;
        state_nx  = EMIT;
      end
      EMIT:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Code fields are loaded on entry to EMIT and then held until the next code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_byte  <= '0;
      alloc_ptr <= '0;
      dict_full <= 1'b0;
      out_hit   <= 1'b0;
      out_new   <= 1'b0;
      out_idx   <= '0;
      out_byte  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register here samples pre-edge values.
      if (accept) begin
        cur_byte <= in_byte;
        if (in_byte == '0) begin
          out_hit  <= 1'b0;
          out_new  <= 1'b0;
          out_idx  <= '0;
          out_byte <= in_byte;
        end
      end
      if (state == RESULT && cam_found) begin
        out_hit  <= 1'b1;
        out_new  <= 1'b0;
        out_idx  <= cam_out & IDX_MASK;
        out_byte <= cur_byte;
      end
      if (state == WRITE) begin
        out_hit   <= 1'b0;
        out_new   <= 1'b1;
        out_idx   <= pad_idx(alloc_ptr);
        out_byte  <= cur_byte;
        alloc_ptr <= alloc_ptr + SIZE_ADDR'(1);
        if (alloc_ptr == SIZE_ADDR'(NB_MEM - 1)) dict_full <= 1'b1;
      end
    end
  end

endmodule
